// File: rtl/operand_fetch_pkg.sv
// Shared widths and index/word types for the operand fetch stage and its
// busy scoreboard.
package operand_fetch_pkg;

    localparam int DW   = 32;
    localparam int NREG = 16;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] word_t;

    // True when an enabled writeback targets the given register index.
    function automatic logic idx_hit(input logic en, input reg_idx_t wr_idx,
                                     input reg_idx_t rd_idx);
        return en && (wr_idx == rd_idx);
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Busy bit per architectural register, with three lookups that already
// account for a writeback retiring the producer in the current cycle.
module operand_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_idx,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_idx,
    input  logic [AW-1:0]        query_a,
    input  logic [AW-1:0]        query_b,
    input  logic [AW-1:0]        query_c,
    output logic                 pending_a,
    output logic                 pending_b,
    output logic                 pending_c
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;

    // A set and a clear to the same index in one cycle leaves the bit set:
    // the newly issued producer now owns the register.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit = idx_hit(set_en, set_idx, reg_idx_t'(gi));
            assign clr_hit = idx_hit(clr_en, clr_idx, reg_idx_t'(gi));
            assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign pending_a = busy_reg[query_a] & ~idx_hit(clr_en, clr_idx, query_a);
    assign pending_b = busy_reg[query_b] & ~idx_hit(clr_en, clr_idx, query_b);
    assign pending_c = busy_reg[query_c] & ~idx_hit(clr_en, clr_idx, query_c);

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute stage: reads operands from the register bank, bypasses
// same-cycle writeback data, stalls on RAW/WAW hazards, one output register.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [AW-1:0] IN_RA,
    input  logic [AW-1:0] IN_RB,
    input  logic          IN_USE_A,
    input  logic          IN_USE_B,
    input  logic [AW-1:0] IN_WC,
    input  logic          IN_WR,
    output logic [AW-1:0] RA,
    output logic [AW-1:0] RB,
    input  logic [DW-1:0] PRA,
    input  logic [DW-1:0] PRB,
    input  logic          W_RB,
    input  logic [AW-1:0] WC,
    input  logic [DW-1:0] WPC,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_A,
    output logic [DW-1:0] OUT_B,
    output logic [AW-1:0] OUT_WC,
    output logic          OUT_WR
);

    logic     pending_a;
    logic     pending_b;
    logic     pending_c;
    logic     hazard;
    logic     stage_free;
    logic     fire;
    logic     bypass_a;
    logic     bypass_b;
    word_t    a_next;
    word_t    b_next;

    logic     out_valid_reg;
    word_t    out_a_reg;
    word_t    out_b_reg;
    reg_idx_t out_wc_reg;
    logic     out_wr_reg;

    assign RA = IN_RA;
    assign RB = IN_RB;

    operand_scoreboard u_scoreboard (
        .clk       (CLK),
        .srst      (RST),
        .set_en    (fire & IN_WR),
        .set_idx   (IN_WC),
        .clr_en    (W_RB),
        .clr_idx   (WC),
        .query_a   (IN_RA),
        .query_b   (IN_RB),
        .query_c   (IN_WC),
        .pending_a (pending_a),
        .pending_b (pending_b),
        .pending_c (pending_c)
    );

    assign hazard     = (IN_USE_A & pending_a) | (IN_USE_B & pending_b) | (IN_WR & pending_c);
    assign stage_free = ~out_valid_reg | OUT_READY;
    assign IN_READY   = ~hazard & stage_free;
    assign fire       = IN_VALID & IN_READY;

    // The bank commits WPC at this same edge, so PRA/PRB still show the old value.
    assign bypass_a = idx_hit(W_RB, WC, IN_RA);
    assign bypass_b = idx_hit(W_RB, WC, IN_RB);
    assign a_next   = bypass_a ? WPC : PRA;
    assign b_next   = bypass_b ? WPC : PRB;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_reg <= 1'b0;
            out_a_reg     <= '0;
            out_b_reg     <= '0;
            out_wc_reg    <= '0;
            out_wr_reg    <= 1'b0;
        end else if (fire) begin
            out_valid_reg <= 1'b1;
            out_a_reg     <= a_next;
            out_b_reg     <= b_next;
            out_wc_reg    <= IN_WC;
            out_wr_reg    <= IN_WR;
        end else if (OUT_READY) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign OUT_VALID = out_valid_reg;
    assign OUT_A     = out_a_reg;
    assign OUT_B     = out_b_reg;
    assign OUT_WC    = out_wc_reg;
    assign OUT_WR    = out_wr_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: models the register bank and busy scoreboard,
// queues expected operands on issue and compares them when execute accepts.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic     CLK = 1'b0;
    logic     RST;
    logic     IN_VALID;
    logic     IN_READY;
    reg_idx_t IN_RA;
    reg_idx_t IN_RB;
    logic     IN_USE_A;
    logic     IN_USE_B;
    reg_idx_t IN_WC;
    logic     IN_WR;
    reg_idx_t RA;
    reg_idx_t RB;
    word_t    PRA;
    word_t    PRB;
    logic     W_RB;
    reg_idx_t WC;
    word_t    WPC;
    logic     OUT_VALID;
    logic     OUT_READY;
    word_t    OUT_A;
    word_t    OUT_B;
    reg_idx_t OUT_WC;
    logic     OUT_WR;

    operand_fetch dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_RA(IN_RA), .IN_RB(IN_RB), .IN_USE_A(IN_USE_A), .IN_USE_B(IN_USE_B),
        .IN_WC(IN_WC), .IN_WR(IN_WR),
        .RA(RA), .RB(RB), .PRA(PRA), .PRB(PRB),
        .W_RB(W_RB), .WC(WC), .WPC(WPC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_WC(OUT_WC), .OUT_WR(OUT_WR)
    );

    always #5 CLK = ~CLK;

    word_t bank [NREG];
    assign PRA = bank[RA];
    assign PRB = bank[RB];

    typedef struct packed {
        word_t    a;
        word_t    b;
        reg_idx_t wc;
        logic     wr;
        logic     use_a;
        logic     use_b;
    } exp_t;

    exp_t            exp_q[$];
    logic [NREG-1:0] m_busy;
    logic            m_out_v;
    logic            last_fire;
    int              checks = 0;
    int              errors = 0;

    task automatic idle();
        IN_VALID = 1'b0; IN_RA = '0; IN_RB = '0; IN_USE_A = 1'b0; IN_USE_B = 1'b0;
        IN_WC = '0; IN_WR = 1'b0; W_RB = 1'b0; WC = '0; WPC = '0;
    endtask

    task automatic set_instr(input reg_idx_t ra, input reg_idx_t rb, input logic ua,
                             input logic ub, input reg_idx_t wc, input logic wr);
        IN_VALID = 1'b1; IN_RA = ra; IN_RB = rb; IN_USE_A = ua; IN_USE_B = ub;
        IN_WC = wc; IN_WR = wr;
    endtask

    // One clock: check handshake against the model, pop/push the scoreboard,
    // advance the model, and commit the bank write after the DUT has sampled.
    task automatic cycle();
        exp_t     e;
        exp_t     g;
        logic     haz;
        logic     exp_ready;
        logic     fire;
        logic     wr_en;
        reg_idx_t wr_idx;
        word_t    wr_dat;
        #1;
        haz = (IN_USE_A && m_busy[IN_RA] && !(W_RB && WC == IN_RA)) ||
              (IN_USE_B && m_busy[IN_RB] && !(W_RB && WC == IN_RB)) ||
              (IN_WR    && m_busy[IN_WC] && !(W_RB && WC == IN_WC));
        exp_ready = !haz && (!m_out_v || OUT_READY);
        checks++;
        if (IN_READY !== exp_ready) begin
            errors++;
            $display("FAIL in_ready t=%0t got %b expected %b", $time, IN_READY, exp_ready);
        end
        checks++;
        if (OUT_VALID !== m_out_v) begin
            errors++;
            $display("FAIL out_valid t=%0t got %b expected %b", $time, OUT_VALID, m_out_v);
        end
        if (m_out_v && OUT_READY && !RST) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow t=%0t got output expected none", $time);
            end else begin
                g = exp_q.pop_front();
                checks++;
                if (OUT_WC !== g.wc || OUT_WR !== g.wr) begin
                    errors++;
                    $display("FAIL out_dest t=%0t got wc=%0d wr=%b expected wc=%0d wr=%b",
                             $time, OUT_WC, OUT_WR, g.wc, g.wr);
                end
                if (g.use_a) begin
                    checks++;
                    if (OUT_A !== g.a) begin
                        errors++;
                        $display("FAIL out_a t=%0t got %h expected %h", $time, OUT_A, g.a);
                    end
                end
                if (g.use_b) begin
                    checks++;
                    if (OUT_B !== g.b) begin
                        errors++;
                        $display("FAIL out_b t=%0t got %h expected %h", $time, OUT_B, g.b);
                    end
                end
            end
        end
        fire = IN_VALID && exp_ready && !RST;
        if (fire) begin
            e.a     = (W_RB && WC == IN_RA) ? WPC : bank[IN_RA];
            e.b     = (W_RB && WC == IN_RB) ? WPC : bank[IN_RB];
            e.wc    = IN_WC;
            e.wr    = IN_WR;
            e.use_a = IN_USE_A;
            e.use_b = IN_USE_B;
            exp_q.push_back(e);
        end
        if (RST) begin
            m_busy  = '0;
            m_out_v = 1'b0;
            exp_q.delete();
        end else begin
            if (W_RB) m_busy[WC] = 1'b0;
            if (fire && IN_WR) m_busy[IN_WC] = 1'b1;
            m_out_v = fire || (m_out_v && !OUT_READY);
        end
        last_fire = fire;
        wr_en  = W_RB;
        wr_idx = WC;
        wr_dat = WPC;
        @(posedge CLK);
        @(negedge CLK);
        if (wr_en) bank[wr_idx] = wr_dat;
    endtask

    task automatic test_reset();
        RST = 1'b1; idle(); OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_WC !== '0 || OUT_WR !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b wc=%0d wr=%b expected 0 0 0", OUT_VALID, OUT_WC, OUT_WR);
        end
        checks++;
        if (OUT_A !== '0 || OUT_B !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h expected 0 0", OUT_A, OUT_B);
        end
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b expected 1", IN_READY);
        end
        cycle();
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_plain_issue();
        idle(); OUT_READY = 1'b1;
        W_RB = 1'b1; WC = 4'd3; WPC = 32'h0000_1111; cycle();
        WC = 4'd4; WPC = 32'h2222_3333; cycle();
        idle();
        set_instr(4'd3, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0);
        cycle();
        idle();
        #1;
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 32'h0000_1111 || OUT_B !== 32'h2222_3333) begin
            errors++;
            $display("FAIL plain_issue got v=%b a=%h b=%h expected 1 00001111 22223333",
                     OUT_VALID, OUT_A, OUT_B);
        end
        cycle();
        $display("test_plain_issue done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_raw_stall();
        idle(); OUT_READY = 1'b1;
        set_instr(4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1);
        cycle();
        set_instr(4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (IN_READY !== 1'b0) begin
                errors++;
                $display("FAIL raw_stall cycle %0d got in_ready=%b expected 0", i, IN_READY);
            end
            cycle();
        end
        W_RB = 1'b1; WC = 4'd5; WPC = 32'hCAFE_F00D;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL raw_release got in_ready=%b expected 1", IN_READY);
        end
        cycle();
        idle();
        #1;
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL raw_bypass got v=%b a=%h expected 1 cafef00d", OUT_VALID, OUT_A);
        end
        cycle();
        $display("test_raw_stall done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_backpressure();
        idle(); OUT_READY = 1'b0;
        set_instr(4'd3, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0);
        cycle();
        set_instr(4'd4, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 ||
                OUT_A !== 32'h0000_1111 || OUT_B !== 32'h2222_3333) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d got rdy=%b v=%b a=%h b=%h expected 0 1 00001111 22223333",
                         i, IN_READY, OUT_VALID, OUT_A, OUT_B);
            end
            cycle();
        end
        OUT_READY = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release got in_ready=%b expected 1", IN_READY);
        end
        cycle();
        idle();
        #1;
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 32'h2222_3333 || OUT_B !== 32'h0000_1111) begin
            errors++;
            $display("FAIL backpressure_next got v=%b a=%h b=%h expected 1 22223333 00001111",
                     OUT_VALID, OUT_A, OUT_B);
        end
        cycle();
        $display("test_backpressure done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_waw_set_wins();
        idle(); OUT_READY = 1'b1;
        set_instr(4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1);
        cycle();
        set_instr(4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1);
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall got in_ready=%b expected 0", IN_READY);
        end
        cycle();
        W_RB = 1'b1; WC = 4'd7; WPC = 32'h1234_5678;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL waw_accept got in_ready=%b expected 1", IN_READY);
        end
        cycle();
        idle();
        set_instr(4'd7, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL set_wins got in_ready=%b expected 0 (busy[7] still set)", IN_READY);
        end
        cycle();
        W_RB = 1'b1; WC = 4'd7; WPC = 32'h9ABC_DEF0;
        cycle();
        idle();
        #1;
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_A !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL waw_final_read got v=%b a=%h expected 1 9abcdef0", OUT_VALID, OUT_A);
        end
        cycle();
        $display("test_waw_set_wins done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_midstream();
        idle(); OUT_READY = 1'b0;
        set_instr(4'd3, 4'd4, 1'b1, 1'b1, 4'd9, 1'b1);
        cycle();
        set_instr(4'd9, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        cycle();
        idle(); RST = 1'b1;
        cycle();
        cycle();
        RST = 1'b0; OUT_READY = 1'b1;
        IN_RA = 4'd9; IN_USE_A = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready got %b expected 1", IN_READY);
        end
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_A !== '0 || OUT_B !== '0 || OUT_WC !== '0 || OUT_WR !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b a=%h b=%h wc=%0d wr=%b expected all 0",
                     OUT_VALID, OUT_A, OUT_B, OUT_WC, OUT_WR);
        end
        cycle();
        IN_VALID = 1'b1;
        cycle();
        idle();
        cycle();
        $display("test_reset_midstream done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        reg_idx_t wb_q[$];
        reg_idx_t r;
        int       issued = 0;
        int       cyc    = 0;
        int       drain  = 0;
        idle(); last_fire = 1'b0;
        while (issued < 1000 && cyc < 30000) begin
            OUT_READY = ($urandom_range(0, 3) != 0);
            W_RB = 1'b0; WC = '0; WPC = '0;
            if (wb_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                W_RB = 1'b1; WC = wb_q.pop_front(); WPC = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                r = reg_idx_t'($urandom_range(0, NREG - 1));
                if (!m_busy[r]) begin
                    W_RB = 1'b1; WC = r; WPC = $urandom;
                end
            end
            if (m_out_v && OUT_READY && exp_q.size() > 0 && exp_q[0].wr)
                wb_q.push_back(exp_q[0].wc);
            if (!IN_VALID || last_fire) begin
                IN_VALID = ($urandom_range(0, 4) != 0);
                IN_RA    = reg_idx_t'($urandom_range(0, NREG - 1));
                IN_RB    = reg_idx_t'($urandom_range(0, NREG - 1));
                IN_USE_A = ($urandom_range(0, 3) != 0);
                IN_USE_B = ($urandom_range(0, 3) != 0);
                IN_WC    = reg_idx_t'($urandom_range(0, NREG - 1));
                IN_WR    = ($urandom_range(0, 2) != 0);
            end
            cycle();
            cyc++;
            if (last_fire) issued++;
        end
        checks++;
        if (issued < 1000) begin
            errors++;
            $display("FAIL random_progress got %0d issued expected 1000 within budget", issued);
        end
        idle(); OUT_READY = 1'b1;
        while ((wb_q.size() > 0 || m_out_v) && drain < 200) begin
            W_RB = 1'b0; WC = '0; WPC = '0;
            if (m_out_v && exp_q.size() > 0 && exp_q[0].wr)
                wb_q.push_back(exp_q[0].wc);
            if (wb_q.size() > 0) begin
                W_RB = 1'b1; WC = wb_q.pop_front(); WPC = $urandom;
            end
            cycle();
            drain++;
        end
        idle();
        cycle();
        checks++;
        if (exp_q.size() != 0 || m_busy != '0) begin
            errors++;
            $display("FAIL random_drain got pending=%0d busy=%h expected 0 0", exp_q.size(), m_busy);
        end
        $display("test_random done issued=%0d cycles=%0d checks=%0d errors=%0d", issued, cyc, checks, errors);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) bank[i] = '0;
        m_busy    = '0;
        m_out_v   = 1'b0;
        last_fire = 1'b0;
        OUT_READY = 1'b1;
        RST       = 1'b1;
        idle();
        test_reset();
        test_plain_issue();
        test_raw_stall();
        test_backpressure();
        test_waw_set_wins();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
